cavlc_coeff_scan: RTL and testbench
===================================

# cavlc_coeff_scan

Reverse-zigzag scanner for the CAVLC encoder. Walks the 16 coefficients of the 4x4 coefficient buffer from high to low frequency by driving its index port and sampling its combinational coefficient output. Produces the per-block CAVLC summary (TotalCoeff, TrailingOnes, T1 signs, TotalZeros) and a back-pressured stream of (level, run_before) entries for the downstream level/run encoder.

## Interface
- No parameters.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  buffer holds a new block; accepted only in IDLE
- busy_o  out  1  high from the cycle after start is accepted until done; upstream must not reload the buffer while high
- coeff_idx_o  out  4  scan index to the buffer (0 = highest frequency)
- coeff_i  in  8  signed two's-complement coefficient from the buffer for coeff_idx_o, same cycle
- lvl_valid_o  out  1  level entry valid
- lvl_ready_i  in  1  downstream accepts the entry
- lvl_level_o  out  8  signed level
- lvl_run_o  out  4  run_before: zeros following this coefficient in scan order
- lvl_t1_o  out  1  entry is a trailing one
- lvl_last_o  out  1  final entry of the block
- done_o  out  1  one-cycle pulse; summary outputs valid
- total_coeff_o  out  5  nonzero count, 0..16
- trailing_ones_o  out  2  0..3
- t1_signs_o  out  3  bit k = sign of k-th trailing one in scan order (1 = negative)
- total_zeros_o  out  4  zeros scanned after the first nonzero

## Operation
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE: start_i -> SCAN; coeff_idx_o <= 0; clear counters, pending register, t1 tracking.
- SCAN, each non-stalled cycle, sample c = coeff_i:
  - c == 0, pending valid: pending.run += 1; total_zeros += 1.
  - c == 0, no pending: no effect.
  - c != 0: total_coeff += 1; if pending valid, move pending to output register; pending <= {c, run 0}.
  - Trailing ones: while t1 tracking open and trailing_ones < 3, |c| == 1 increments trailing_ones, records sign, flags entry t1; any other nonzero closes tracking.
  - coeff_idx_o increments; after idx 15 is processed -> FLUSH.
- Stall: a nonzero needs the output register while lvl_valid_o && !lvl_ready_i -> nothing updates, coeff_idx_o holds.
- FLUSH: when the output register is free or being accepted, move pending (if any) out with lvl_last_o = 1 -> DONE. If total_coeff == 0, no entry is emitted.
- DONE: assert done_o one cycle -> IDLE. Summary outputs hold until next start.
- Output register: lvl_valid_o stays high, data stable, until lvl_ready_i; valid/ready handshake, no combinational ready->valid path.
- start_i outside IDLE is ignored.

## Timing
- Reset: state IDLE; all outputs 0 (coeff_idx_o 0, busy_o 0, lvl_valid_o 0, done_o 0, summary 0).
- Start accepted at edge 0; SCAN samples idx 0..15 on edges 1..16; FLUSH edge 17; done_o high during cycle after edge 18 when unstalled. Minimum start-to-done 18 cycles; each stall cycle adds one.
- Last entry may be accepted on the same cycle done_o is high, or later; done_o does not wait for acceptance of the final entry, but next SCAN cannot emit until it is accepted.
- Reset asserted mid-scan: immediate return to IDLE, pending and output entries dropped.
- Counters never wrap: run max 15, total_zeros max 15, total_coeff max 16.

## Configuration
- CAVLC_TRAIL_ONES_EN defined: trailing-ones tracking as above.
- Not defined: trailing_ones_o, t1_signs_o, lvl_t1_o tied 0; all other behaviour identical.

## Test plan
- All-zero block, lvl_ready_i = 1 -> no lvl_valid_o, done_o 18 cycles after start, total_coeff 0, total_zeros 0.
- Scan-order coeffs idx7=1, idx9=1, idx10=-1, idx13=-1, idx14=3, rest 0 -> entries (1,1,t1),(1,0,t1),(-1,2,t1),(-1,0),(3,1,last); total_coeff 5, trailing_ones 3, t1_signs 3'b100, total_zeros 4.
- Same block, lvl_ready_i low cycles 10-14 -> coeff_idx_o frozen during stall, identical entry sequence, done 5 cycles later.
- All 16 coeffs = 2 -> 16 entries run 0, trailing_ones 0, total_zeros 0; only idx15 entry has last.
- Only idx0 = -1 -> one entry (-1,15,t1,last), total_zeros 15, t1_signs 3'b001.
- rst_n pulsed low at idx 8, then new start -> outputs 0 during reset, second block summary independent of first.

Source files
------------

// File: rtl/cavlc_coeff_scan_if.sv
// Level/run entry stream from the coefficient scanner to the level/run encoder.
// The scanner drives the master side; the downstream encoder uses the slave side.
interface cavlc_coeff_scan_if;
  logic       lvl_valid;
  logic       lvl_ready;
  logic [7:0] lvl_level;
  logic [3:0] lvl_run;
  logic       lvl_t1;
  logic       lvl_last;

  modport master (
    output lvl_valid,
    output lvl_level,
    output lvl_run,
    output lvl_t1,
    output lvl_last,
    input  lvl_ready
  );

  modport slave (
    input  lvl_valid,
    input  lvl_level,
    input  lvl_run,
    input  lvl_t1,
    input  lvl_last,
    output lvl_ready
  );
endinterface

// File: rtl/cavlc_coeff_scan.sv
// Reverse-zigzag CAVLC coefficient scanner: block summary plus (level, run_before) stream.
// Optional feature macro: CAVLC_TRAIL_ONES_EN enables trailing-ones tracking.
module cavlc_coeff_scan (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic [3:0]                coeff_idx_o,
  input  logic signed [7:0]         coeff_i,
  cavlc_coeff_scan_if.master        lvl,
  output logic                      done_o,
  output logic [4:0]                total_coeff_o,
  output logic [1:0]                trailing_ones_o,
  output logic [2:0]                t1_signs_o,
  output logic [3:0]                total_zeros_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [4:0] tc_q, tc_d;
  logic [3:0] tz_q, tz_d;

  logic       pend_vld_q, pend_vld_d;
  logic [7:0] pend_lvl_q, pend_lvl_d;
  logic [3:0] pend_run_q, pend_run_d;
  logic       pend_t1_q, pend_t1_d;

  logic       out_vld_q, out_vld_d;
  logic [7:0] out_lvl_q, out_lvl_d;
  logic [3:0] out_run_q, out_run_d;
  logic       out_t1_q, out_t1_d;
  logic       out_last_q, out_last_d;

  logic       coeff_nz;
  logic       out_free;
  logic       advance;

`ifdef CAVLC_TRAIL_ONES_EN
  logic [1:0] t1cnt_q, t1cnt_d;
  logic [2:0] t1sgn_q, t1sgn_d;
  logic       t1open_q, t1open_d;
  logic       coeff_mag1;

  assign coeff_mag1 = (coeff_i == 8'sd1) || (coeff_i == -8'sd1);
`endif

  assign coeff_nz = (coeff_i != 8'sd0);
  // The output register can take a new entry if empty or being handed off this cycle.
  assign out_free = !out_vld_q || lvl.lvl_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tc_d       = tc_q;
    tz_d       = tz_q;
    pend_vld_d = pend_vld_q;
    pend_lvl_d = pend_lvl_q;
    pend_run_d = pend_run_q;
    pend_t1_d  = pend_t1_q;
    out_vld_d  = out_vld_q;
    out_lvl_d  = out_lvl_q;
    out_run_d  = out_run_q;
    out_t1_d   = out_t1_q;
    out_last_d = out_last_q;
    advance    = 1'b0;
`ifdef CAVLC_TRAIL_ONES_EN
    t1cnt_d    = t1cnt_q;
    t1sgn_d    = t1sgn_q;
    t1open_d   = t1open_q;
`endif

    if (out_vld_q && lvl.lvl_ready) begin
      out_vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_SCAN;
          idx_d      = 4'd0;
          busy_d     = 1'b1;
          tc_d       = 5'd0;
          tz_d       = 4'd0;
          pend_vld_d = 1'b0;
          pend_lvl_d = 8'd0;
          pend_run_d = 4'd0;
          pend_t1_d  = 1'b0;
`ifdef CAVLC_TRAIL_ONES_EN
          t1cnt_d    = 2'd0;
          t1sgn_d    = 3'd0;
          t1open_d   = 1'b1;
`endif
        end
      end

      S_SCAN: begin
        if (!coeff_nz) begin
          // Zeros before the first nonzero carry no run information.
          if (pend_vld_q) begin
            if (pend_run_q != 4'd15) pend_run_d = pend_run_q + 4'd1;
            if (tz_q != 4'd15)       tz_d       = tz_q + 4'd1;
          end
          advance = 1'b1;
        end else if (out_free) begin
          if (tc_q != 5'd16) tc_d = tc_q + 5'd1;
          if (pend_vld_q) begin
            out_vld_d  = 1'b1;
            out_lvl_d  = pend_lvl_q;
            out_run_d  = pend_run_q;
            out_t1_d   = pend_t1_q;
            out_last_d = 1'b0;
          end
          pend_vld_d = 1'b1;
          pend_lvl_d = coeff_i;
          pend_run_d = 4'd0;
          pend_t1_d  = 1'b0;
`ifdef CAVLC_TRAIL_ONES_EN
          if (t1open_q && (t1cnt_q != 2'd3)) begin
            if (coeff_mag1) begin
              t1cnt_d   = t1cnt_q + 2'd1;
              pend_t1_d = 1'b1;
              case (t1cnt_q)
                2'd0:    t1sgn_d[0] = coeff_i[7];
                2'd1:    t1sgn_d[1] = coeff_i[7];
                default: t1sgn_d[2] = coeff_i[7];
              endcase
            end else begin
              t1open_d = 1'b0;
            end
          end
`endif
          advance = 1'b1;
        end

        if (advance) begin
          if (idx_q == 4'd15) begin
            state_d = S_FLUSH;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      S_FLUSH: begin
        if (!pend_vld_q) begin
          state_d = S_DONE;
        end else if (out_free) begin
          out_vld_d  = 1'b1;
          out_lvl_d  = pend_lvl_q;
          out_run_d  = pend_run_q;
          out_t1_d   = pend_t1_q;
          out_last_d = 1'b1;
          pend_vld_d = 1'b0;
          state_d    = S_DONE;
        end
      end

      default: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tc_q       <= 5'd0;
      tz_q       <= 4'd0;
      pend_vld_q <= 1'b0;
      pend_lvl_q <= 8'd0;
      pend_run_q <= 4'd0;
      pend_t1_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_lvl_q  <= 8'd0;
      out_run_q  <= 4'd0;
      out_t1_q   <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tc_q       <= tc_d;
      tz_q       <= tz_d;
      pend_vld_q <= pend_vld_d;
      pend_lvl_q <= pend_lvl_d;
      pend_run_q <= pend_run_d;
      pend_t1_q  <= pend_t1_d;
      out_vld_q  <= out_vld_d;
      out_lvl_q  <= out_lvl_d;
      out_run_q  <= out_run_d;
      out_t1_q   <= out_t1_d;
      out_last_q <= out_last_d;
    end
  end

`ifdef CAVLC_TRAIL_ONES_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1cnt_q  <= 2'd0;
      t1sgn_q  <= 3'd0;
      t1open_q <= 1'b0;
    end else begin
      t1cnt_q  <= t1cnt_d;
      t1sgn_q  <= t1sgn_d;
      t1open_q <= t1open_d;
    end
  end

  assign trailing_ones_o = t1cnt_q;
  assign t1_signs_o      = t1sgn_q;
`else
  assign trailing_ones_o = 2'd0;
  assign t1_signs_o      = 3'd0;
`endif

  assign busy_o        = busy_q;
  assign coeff_idx_o   = idx_q;
  assign done_o        = done_q;
  assign total_coeff_o = tc_q;
  assign total_zeros_o = tz_q;

  assign lvl.lvl_valid = out_vld_q;
  assign lvl.lvl_level = out_lvl_q;
  assign lvl.lvl_run   = out_run_q;
  assign lvl.lvl_t1    = out_t1_q;
  assign lvl.lvl_last  = out_last_q;

endmodule

// File: tb/tb_cavlc_coeff_scan.sv
// Table-driven bench for cavlc_coeff_scan: each record holds a 4x4 block in scan order,
// a downstream stall window and the expected summary and entry stream.
module tb_cavlc_coeff_scan;

  typedef struct packed {
    logic [7:0] level;
    logic [3:0] run;
    logic       t1;
    logic       last;
  } entry_t;

  typedef struct {
    logic [15:0][7:0] coeffs;
    int               stallFrom;
    int               stallLen;
    int               expDone;
    logic [4:0]       expTc;
    logic [1:0]       expT1;
    logic [2:0]       expSgn;
    logic [3:0]       expTz;
    int               nEnt;
    entry_t [15:0]    ent;
  } blockVec_t;

`ifdef CAVLC_TRAIL_ONES_EN
  localparam bit T1En = 1'b1;
`else
  localparam bit T1En = 1'b0;
`endif
  localparam int NumVec    = 7;
  localparam int RunCycles = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic [3:0]       coeffIdx;
  logic [7:0]       coeffIn;
  logic             done;
  logic [4:0]       totalCoeff;
  logic [1:0]       trailingOnes;
  logic [2:0]       t1Signs;
  logic [3:0]       totalZeros;
  logic [15:0][7:0] memBuf;

  cavlc_coeff_scan_if lvlBus ();

  cavlc_coeff_scan dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .busy_o          (busy),
    .coeff_idx_o     (coeffIdx),
    .coeff_i         (coeffIn),
    .lvl             (lvlBus),
    .done_o          (done),
    .total_coeff_o   (totalCoeff),
    .trailing_ones_o (trailingOnes),
    .t1_signs_o      (t1Signs),
    .total_zeros_o   (totalZeros)
  );

  always #5 clk = ~clk;

  // Behavioural coefficient buffer: combinational read at the scanner's index.
  assign coeffIn = memBuf[coeffIdx];

  blockVec_t vecs [NumVec];
  entry_t    got [$];
  int        doneAt;
  int        doneCount;
  logic [3:0] idxLog   [RunCycles];
  logic       busyLog  [RunCycles];
  logic       validLog [RunCycles];
  entry_t     outLog   [RunCycles];
  int         checkCount = 0;
  int         passCount  = 0;

  function automatic entry_t mkEnt(input logic [7:0] l, input logic [3:0] r,
                                   input logic t, input logic last);
    entry_t e;
    e.level = l;
    e.run   = r;
    e.t1    = t;
    e.last  = last;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".idx"},   {28'd0, coeffIdx}, 32'd0);
    checkOutput({tag, ".busy"},  {31'd0, busy}, 32'd0);
    checkOutput({tag, ".valid"}, {31'd0, lvlBus.lvl_valid}, 32'd0);
    checkOutput({tag, ".done"},  {31'd0, done}, 32'd0);
    checkOutput({tag, ".summary"},
                {18'd0, totalCoeff, trailingOnes, t1Signs, totalZeros}, 32'd0);
  endtask

  // Starts one block and records the DUT's outputs for a fixed number of cycles;
  // cycle k is the cycle following edge k, where edge 0 accepts start.
  task automatic applyStimulus(input int v);
    got.delete();
    doneAt    = -1;
    doneCount = 0;
    memBuf    = vecs[v].coeffs;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < RunCycles; k++) begin
      lvlBus.lvl_ready = !(k >= vecs[v].stallFrom && k < vecs[v].stallFrom + vecs[v].stallLen);
      #1;
      idxLog[k]   = coeffIdx;
      busyLog[k]  = busy;
      validLog[k] = lvlBus.lvl_valid;
      outLog[k]   = {lvlBus.lvl_level, lvlBus.lvl_run, lvlBus.lvl_t1, lvlBus.lvl_last};
      if (lvlBus.lvl_valid && lvlBus.lvl_ready) got.push_back(outLog[k]);
      if (done) begin
        if (doneAt < 0) doneAt = k;
        doneCount++;
      end
      @(negedge clk);
    end
  endtask

  task automatic runVector(input int v);
    entry_t e;
    logic [31:0] act;
    string tag;
    applyStimulus(v);
    tag = $sformatf("v%0d", v);
    checkOutput({tag, ".doneCycle"}, doneAt, vecs[v].expDone);
    checkOutput({tag, ".donePulses"}, doneCount, 32'd1);
    checkOutput({tag, ".busyMid"}, {31'd0, busyLog[5]}, 32'd1);
    if (doneAt >= 0) checkOutput({tag, ".busyAtDone"}, {31'd0, busyLog[doneAt]}, 32'd0);
    checkOutput({tag, ".totalCoeff"}, {27'd0, totalCoeff}, {27'd0, vecs[v].expTc});
    checkOutput({tag, ".trailingOnes"}, {30'd0, trailingOnes},
                {30'd0, T1En ? vecs[v].expT1 : 2'd0});
    checkOutput({tag, ".t1Signs"}, {29'd0, t1Signs}, {29'd0, T1En ? vecs[v].expSgn : 3'd0});
    checkOutput({tag, ".totalZeros"}, {28'd0, totalZeros}, {28'd0, vecs[v].expTz});
    checkOutput({tag, ".entryCount"}, got.size(), vecs[v].nEnt);
    for (int j = 0; j < vecs[v].nEnt; j++) begin
      e    = vecs[v].ent[j];
      e.t1 = e.t1 & T1En;
      act  = (j < got.size()) ? {18'd0, got[j]} : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s.entry%0d", tag, j), act, {18'd0, e});
    end
  endtask

  initial begin
    for (int v = 0; v < NumVec; v++) begin
      vecs[v].coeffs    = '0;
      vecs[v].stallFrom = 0;
      vecs[v].stallLen  = 0;
      vecs[v].expDone   = 18;
      vecs[v].expTc     = 5'd0;
      vecs[v].expT1     = 2'd0;
      vecs[v].expSgn    = 3'd0;
      vecs[v].expTz     = 4'd0;
      vecs[v].nEnt      = 0;
      vecs[v].ent       = '0;
    end
    // v1: mixed block with three trailing ones
    vecs[1].coeffs[7]  = 8'h01;
    vecs[1].coeffs[9]  = 8'h01;
    vecs[1].coeffs[10] = 8'hFF;
    vecs[1].coeffs[13] = 8'hFF;
    vecs[1].coeffs[14] = 8'h03;
    vecs[1].expTc  = 5'd5;
    vecs[1].expT1  = 2'd3;
    vecs[1].expSgn = 3'b100;
    vecs[1].expTz  = 4'd4;
    vecs[1].nEnt   = 5;
    vecs[1].ent[0] = mkEnt(8'h01, 4'd1, 1'b1, 1'b0);
    vecs[1].ent[1] = mkEnt(8'h01, 4'd0, 1'b1, 1'b0);
    vecs[1].ent[2] = mkEnt(8'hFF, 4'd2, 1'b1, 1'b0);
    vecs[1].ent[3] = mkEnt(8'hFF, 4'd0, 1'b0, 1'b0);
    vecs[1].ent[4] = mkEnt(8'h03, 4'd1, 1'b0, 1'b1);
    // v2: same block, downstream stalls cycles 10..14
    vecs[2] = vecs[1];
    vecs[2].stallFrom = 10;
    vecs[2].stallLen  = 5;
    vecs[2].expDone   = 23;
    // v3: all coefficients 2
    for (int j = 0; j < 16; j++) begin
      vecs[3].coeffs[j] = 8'h02;
      vecs[3].ent[j]    = mkEnt(8'h02, 4'd0, 1'b0, j == 15);
    end
    vecs[3].expTc = 5'd16;
    vecs[3].nEnt  = 16;
    // v4: single -1 at the highest frequency, maximal run
    vecs[4].coeffs[0] = 8'hFF;
    vecs[4].expTc  = 5'd1;
    vecs[4].expT1  = 2'd1;
    vecs[4].expSgn = 3'b001;
    vecs[4].expTz  = 4'd15;
    vecs[4].nEnt   = 1;
    vecs[4].ent[0] = mkEnt(8'hFF, 4'd15, 1'b1, 1'b1);
    // v5: four +-1 values, only the first three count as trailing ones
    vecs[5].coeffs[0] = 8'h01;
    vecs[5].coeffs[1] = 8'hFF;
    vecs[5].coeffs[2] = 8'h01;
    vecs[5].coeffs[3] = 8'hFF;
    vecs[5].expTc  = 5'd4;
    vecs[5].expT1  = 2'd3;
    vecs[5].expSgn = 3'b010;
    vecs[5].expTz  = 4'd12;
    vecs[5].nEnt   = 4;
    vecs[5].ent[0] = mkEnt(8'h01, 4'd0, 1'b1, 1'b0);
    vecs[5].ent[1] = mkEnt(8'hFF, 4'd0, 1'b1, 1'b0);
    vecs[5].ent[2] = mkEnt(8'h01, 4'd0, 1'b1, 1'b0);
    vecs[5].ent[3] = mkEnt(8'hFF, 4'd12, 1'b0, 1'b1);
    // v6: a larger level first closes trailing-ones tracking
    vecs[6].coeffs[0] = 8'h02;
    vecs[6].coeffs[1] = 8'h01;
    vecs[6].expTc  = 5'd2;
    vecs[6].expTz  = 4'd14;
    vecs[6].nEnt   = 2;
    vecs[6].ent[0] = mkEnt(8'h02, 4'd0, 1'b0, 1'b0);
    vecs[6].ent[1] = mkEnt(8'h01, 4'd14, 1'b0, 1'b1);

    rst_n            = 1'b0;
    start            = 1'b0;
    memBuf           = '0;
    lvlBus.lvl_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    for (int v = 0; v < NumVec; v++) begin
      runVector(v);
      if (v == 2) begin
        checkOutput("v2.idxStallStart", {28'd0, idxLog[10]}, 32'd10);
        checkOutput("v2.idxStallEnd",   {28'd0, idxLog[14]}, 32'd10);
        checkOutput("v2.idxResume",     {28'd0, idxLog[16]}, 32'd11);
        checkOutput("v2.validHeld",     {31'd0, validLog[14]}, 32'd1);
        checkOutput("v2.dataHeld",      {18'd0, outLog[14]},
                    {18'd0, mkEnt(8'h01, 4'd1, T1En, 1'b0)});
      end
    end

    // Reset in the middle of a scan, then an unrelated block.
    memBuf = vecs[1].coeffs;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    checkOutput("midReset.idxBefore", {28'd0, coeffIdx}, 32'd8);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    runVector(4);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
